// File: rtl/sensor_measure_scheduler_pkg.sv
// Shared definitions for the two-sensor ultrasonic measurement scheduler.
//   - sched_state_t : scheduler FSM state encoding
//   - SCHED_DIST_W  : width of a raw distance reading and of a published average
//   - sched_clog2() : ceiling log2, used to size accumulators and counters
package sensor_measure_scheduler_pkg;

    localparam int SCHED_DIST_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_TRIGGER = 3'd2,
        ST_WAIT    = 3'd3,
        ST_CHECK   = 3'd4,
        ST_GAP     = 3'd5
    } sched_state_t;

    // Smallest r with 2**r >= value (0 for value <= 1).
    function automatic int sched_clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/distance_accumulator.sv
// Per-channel block accumulator. Sums readings until NUM_SAMPLES have been
// collected; on publish it latches the truncated mean and restarts the block.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   add_i       : add value_i to the running sum and bump the count
//   value_i     : raw distance reading
//   publish_i   : latch sum >> log2(NUM_SAMPLES) into avg_o, clear sum/count
//   sum_o       : running sum (wide enough that it can never overflow)
//   full_o      : count has reached NUM_SAMPLES
//   avg_o       : most recently published average (registered)
module distance_accumulator
    import sensor_measure_scheduler_pkg::*;
#(
    parameter  int NUM_SAMPLES = 4,
    localparam int SHIFT       = sched_clog2(NUM_SAMPLES),
    localparam int ACC_W       = SCHED_DIST_W + SHIFT,
    localparam int CNT_W       = sched_clog2(NUM_SAMPLES + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    add_i,
    input  logic [SCHED_DIST_W-1:0] value_i,
    input  logic                    publish_i,
    output logic [ACC_W-1:0]        sum_o,
    output logic                    full_o,
    output logic [SCHED_DIST_W-1:0] avg_o
);

    logic [ACC_W-1:0]        acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [SCHED_DIST_W-1:0] avg_q, avg_d;

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        avg_d = avg_q;
        if (publish_i) begin
            // Dropping the low SHIFT bits is the divide; the remaining slice
            // is exactly SCHED_DIST_W wide.
            avg_d = acc_q[ACC_W-1:SHIFT];
            acc_d = '0;
            cnt_d = '0;
        end else if (add_i) begin
            acc_d = acc_q + ACC_W'(value_i);
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
            avg_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            avg_q <= avg_d;
        end
    end

    assign sum_o  = acc_q;
    assign full_o = (cnt_q == CNT_W'(NUM_SAMPLES));
    assign avg_o  = avg_q;

endmodule

// File: rtl/sensor_measure_scheduler.sv
// Time-shares one ultrasonic measurement unit between two sensors and
// publishes a per-sensor block average every NUM_SAMPLES valid readings.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   enable_i          : run measurement passes continuously while high
//   pronto_i          : one-cycle result strobe from the measurement unit
//   medida_i          : raw distance, valid with pronto_i
//   medir_o           : one-cycle trigger to the measurement unit
//   sensor_sel_o      : channel select for the mux ahead of the unit
//   avg_distance_0_o  : latest published average, sensor 0
//   avg_distance_1_o  : latest published average, sensor 1
//   new_average_o     : one-cycle strobe, bit k marks a fresh average k
//   timeout_err_o     : one-cycle strobe, last measurement abandoned
module sensor_measure_scheduler
    import sensor_measure_scheduler_pkg::*;
#(
    parameter int NUM_SAMPLES     = 4,
    parameter int TIMEOUT_CYCLES  = 2500000,
    parameter int INTERVAL_CYCLES = 3000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable_i,
    input  logic                    pronto_i,
    input  logic [SCHED_DIST_W-1:0] medida_i,
    output logic                    medir_o,
    output logic                    sensor_sel_o,
    output logic [SCHED_DIST_W-1:0] avg_distance_0_o,
    output logic [SCHED_DIST_W-1:0] avg_distance_1_o,
    output logic [1:0]              new_average_o,
    output logic                    timeout_err_o
);

    localparam int ACC_W   = SCHED_DIST_W + sched_clog2(NUM_SAMPLES);
    localparam int MAX_CNT = (TIMEOUT_CYCLES > INTERVAL_CYCLES) ? TIMEOUT_CYCLES
                                                                : INTERVAL_CYCLES;
    localparam int CNT_W   = sched_clog2(MAX_CNT + 1);

    sched_state_t state_q, state_d;
    logic [CNT_W-1:0] counter_q, counter_d;
    logic             sel_q, sel_d;
    logic             medir_q, medir_d;
    logic             terr_q, terr_d;
    logic [1:0]       newavg_q, newavg_d;
    logic [1:0]       add_ch;
    logic [1:0]       publish_ch;
    logic [1:0]       full_w;

    logic [SCHED_DIST_W-1:0] avg_w [2];
    // The running sums are not needed by the scheduler itself.
    logic [ACC_W-1:0]        sum_unused [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            distance_accumulator #(
                .NUM_SAMPLES (NUM_SAMPLES)
            ) u_acc (
                .clk       (clk),
                .rst       (rst),
                .add_i     (add_ch[gi]),
                .value_i   (medida_i),
                .publish_i (publish_ch[gi]),
                .sum_o     (sum_unused[gi]),
                .full_o    (full_w[gi]),
                .avg_o     (avg_w[gi])
            );
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        medir_d    = 1'b0;
        terr_d     = 1'b0;
        newavg_d   = 2'b00;
        add_ch     = 2'b00;
        publish_ch = 2'b00;

        case (state_q)
            ST_IDLE: begin
                if (enable_i) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                // Outputs are registered, so the trigger is raised one
                // cycle early to appear exactly while in TRIGGER.
                medir_d = 1'b1;
                state_d = ST_TRIGGER;
            end
            ST_TRIGGER: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A reply in the final wait cycle still counts.
                if (pronto_i) begin
                    add_ch[sel_q] = 1'b1;
                    state_d       = ST_CHECK;
                end else if (counter_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    terr_d  = 1'b1;
                    state_d = ST_GAP;
                end
            end
            ST_CHECK: begin
                if (full_w[sel_q]) begin
                    publish_ch[sel_q] = 1'b1;
                    newavg_d[sel_q]   = 1'b1;
                end
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (counter_q == CNT_W'(INTERVAL_CYCLES - 1)) begin
                    sel_d   = ~sel_q;
                    state_d = enable_i ? ST_SETTLE : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // One counter serves both WAIT and GAP; it restarts on every state
        // change so each of those states begins counting from zero.
        if ((state_d == state_q) && ((state_q == ST_WAIT) || (state_q == ST_GAP))) begin
            counter_d = counter_q + CNT_W'(1);
        end else begin
            counter_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            counter_q <= '0;
            sel_q     <= 1'b0;
            medir_q   <= 1'b0;
            terr_q    <= 1'b0;
            newavg_q  <= 2'b00;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            sel_q     <= sel_d;
            medir_q   <= medir_d;
            terr_q    <= terr_d;
            newavg_q  <= newavg_d;
        end
    end

    assign medir_o          = medir_q;
    assign sensor_sel_o     = sel_q;
    assign timeout_err_o    = terr_q;
    assign new_average_o    = newavg_q;
    assign avg_distance_0_o = avg_w[0];
    assign avg_distance_1_o = avg_w[1];

endmodule

// File: doc/sensor_measure_scheduler.md
# sensor_measure_scheduler

Time-shares one ultrasonic measurement unit between two distance sensors and turns the raw readings into a per-sensor moving-block average. Each pass selects a sensor, fires a measurement, waits for the result or a timeout, and accumulates the result. Every NUM_SAMPLES valid readings it publishes the average with a one-cycle strobe. It sits between the measurement unit and the downstream change-detection and processing logic.

## Interface
- NUM_SAMPLES, 4: valid readings per average; power of two, ≥2
- TIMEOUT_CYCLES, 2500000: maximum wait for `pronto` after `medir` (50 ms at 50 MHz); ≥2
- INTERVAL_CYCLES, 3000000: idle gap between measurements (60 ms at 50 MHz); ≥1
- Clock and reset: one clock; reset is asynchronous and active-high.
- clock  in  1  system clock; all logic on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- enable  in  1  level; 1 = run measurement passes continuously
- pronto  in  1  one-cycle strobe from the measurement unit; `medida` is valid in that cycle
- medida  in  32  raw distance from the measurement unit
- medir  out  1  one-cycle trigger to the measurement unit
- sensor_sel  out  1  drives the mux in front of the shared unit (0 or 1); stable from SETTLE through WAIT
- avg_distance_0  out  32  latest published average, sensor 0
- avg_distance_1  out  32  latest published average, sensor 1
- new_average  out  2  one-cycle strobe; bit k marks a fresh avg_distance_k
- timeout_err  out  1  one-cycle strobe; the last measurement was abandoned

## Operation
- States: IDLE, SETTLE, TRIGGER, WAIT, CHECK, GAP.
- IDLE: stays here while enable=0. When enable=1, goes to SETTLE.
- SETTLE: one cycle for the mux to settle; sensor_sel already holds the current channel. Goes to TRIGGER.
- TRIGGER: medir=1 for exactly one cycle. Clears the wait counter. Goes to WAIT.
- WAIT: counter increments each cycle.
  - pronto=1: add medida to acc[sensor_sel], increment cnt[sensor_sel], go to CHECK.
  - Otherwise, when counter = TIMEOUT_CYCLES-1: strobe timeout_err, discard the sample, go to GAP.
  - If pronto coincides with the timeout cycle, pronto wins and there is no timeout_err.
- CHECK: if cnt[ch] = NUM_SAMPLES, then:
  - avg_distance_ch <= acc[ch] >> log2(NUM_SAMPLES), truncating;
  - strobe new_average[ch];
  - acc[ch] and cnt[ch] clear to 0.
  - Goes to GAP in all cases.
- GAP: counts INTERVAL_CYCLES cycles. On the last cycle, sensor_sel toggles (strict round-robin, including after a timeout). Goes to SETTLE if enable=1, otherwise IDLE.
- enable is sampled only in IDLE and at the end of GAP. A measurement already in progress always completes.
- pronto is ignored outside WAIT.
- Accumulator width is 32+log2(NUM_SAMPLES) bits, so it cannot overflow. Each channel's accumulator and count are independent.
- avg_distance_k holds its value until the next publish for that channel. A published value of 0 is legal.

## Timing
- Reset values:
  - state IDLE; sensor_sel 0; medir 0; new_average 2'b00; timeout_err 0;
  - avg_distance_0 and avg_distance_1 are 0; all accumulators, counts and counters are 0.
- enable=1 in IDLE at cycle t: SETTLE at t+1, medir=1 at t+2, WAIT from t+3.
- pronto at cycle w: CHECK at w+1; new_average[ch] and the updated avg_distance_ch are visible at w+2.
- Timeout: with no pronto, timeout_err=1 exactly TIMEOUT_CYCLES cycles after the first WAIT cycle.
- All outputs are registered. Each strobe is high for exactly one cycle.
- Reset asserted mid-operation: all outputs return to reset values immediately. No medir and no strobe may follow until enable is seen in IDLE.

## Structure
- Shared package/header holds: the state encoding, `SCHED_DIST_W` = 32, and a clog2 helper for the accumulator width.
- One sub-module, `distance_accumulator`, instantiated once per channel.
  - Inputs: add/value, publish.
  - Outputs: sum, count-full flag, averaged result.
  - Owns acc, cnt and the shift.
- The FSM, wait/gap counters and round-robin live in the top module.

## Test plan
All scenarios use NUM_SAMPLES=2, TIMEOUT_CYCLES=16, INTERVAL_CYCLES=4.
- Reset, then enable=1 with pronto replies 10 and 20 on sensor 0 -> medir two cycles after enable; sensor_sel alternates 0,1,0; after the second sensor-0 reading, avg_distance_0=15 and new_average=2'b01 for one cycle.
- Sensor 1 replies 7 and 8 -> avg_distance_1=7 (truncation); new_average=2'b10; avg_distance_0 unchanged.
- No pronto in WAIT -> timeout_err high exactly 16 cycles after WAIT entry; cnt unchanged; next pass uses the other sensor.
- pronto in the timeout cycle with medida=40 -> sample accumulated; no timeout_err.
- Stray pronto during GAP, plus enable dropped mid-WAIT -> stray ignored; the in-flight measurement completes; returns to IDLE with no further medir.
- Reset asserted during WAIT after one accumulated sample -> all outputs 0; the next average needs 2 fresh samples.
